// File: rtl/spi_ad_master.sv
// SPI master for the address/data SPI-to-Wishbone protocol: sends a header word
// {addr, 1'b0, rd}, then cmd_len+1 data words in mode 0, capturing miso on reads.
module spi_ad_master #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int SS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_rd,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  mosi,
  output logic                  ss,
  input  logic                  miso
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GAP_CYC = (SS_GAP * CLK_DIV > 0) ? SS_GAP * CLK_DIV : 1;
  localparam int GAP_W   = $clog2(GAP_CYC) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WORD  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [LEN_WIDTH-1:0]  word_q, word_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_q, rd_d;
  logic                  hdr_q, hdr_d;
  logic                  sck_q, sck_d;
  logic                  ss_q, ss_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;
  logic                  wr_take;
  logic                  tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    word_d     = word_q;
    gap_d      = gap_q;
    shift_d    = shift_q;
    cap_d      = cap_q;
    rd_data_d  = rd_data_q;
    rd_d       = rd_q;
    hdr_d      = hdr_q;
    sck_d      = sck_q;
    ss_d       = ss_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    wr_take    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_SETUP;
          ss_d    = 1'b0;
          shift_d = {cmd_addr, 1'b0, cmd_rd};
          rd_d    = cmd_rd;
          word_d  = cmd_len;
          hdr_d   = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          cap_d   = {cap_q[DATA_WIDTH-2:0], miso};
          div_d   = '0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_SHIFT: begin
        if (tick) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            cap_d = {cap_q[DATA_WIDTH-2:0], miso};
          end else begin
            // Shifting on every fall leaves zeros behind, so mosi idles low after a word.
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = S_WORD;
              if (rd_q && !hdr_q) begin
                rd_data_d  = cap_q;
                rd_valid_d = 1'b1;
              end
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_WORD: begin
        if (!hdr_q && word_q == '0) begin
          // The boundary cycle counts as the first hold cycle.
          state_d = S_HOLD;
          div_d   = DIV_W'(1);
        end else if (rd_q) begin
          state_d = S_SETUP;
          div_d   = '0;
          shift_d = '0;
          hdr_d   = 1'b0;
          if (!hdr_q) word_d = word_q - LEN_WIDTH'(1);
        end else if (wr_valid) begin
          wr_take = 1'b1;
          state_d = S_SETUP;
          div_d   = '0;
          shift_d = wr_data;
          hdr_d   = 1'b0;
          if (!hdr_q) word_d = word_q - LEN_WIDTH'(1);
        end
      end
      S_HOLD: begin
        if (tick) begin
          ss_d    = 1'b1;
          done_d  = 1'b1;
          div_d   = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      gap_q      <= '0;
      shift_q    <= '0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_q       <= 1'b0;
      hdr_q      <= 1'b0;
      sck_q      <= 1'b0;
      ss_q       <= 1'b1;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      gap_q      <= gap_d;
      shift_q    <= shift_d;
      cap_q      <= cap_d;
      rd_data_q  <= rd_data_d;
      rd_q       <= rd_d;
      hdr_q      <= hdr_d;
      sck_q      <= sck_d;
      ss_q       <= ss_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign wr_ready  = wr_take && !reset;
  assign busy      = (state_q != S_IDLE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign sck       = sck_q;
  assign ss        = ss_q;
  assign mosi      = shift_q[DATA_WIDTH-1];

endmodule
